// File: rtl/wb_arbiter2_if.sv
// Pipelined Wishbone link between one master and one slave.
// The master modport drives the request side; the slave modport drives the response side.
interface wb_arbiter2_if #(
    parameter int AWIDTH = 32,
    parameter int DWIDTH = 32
);
    logic                cyc;
    logic                stb;
    logic                we;
    logic [AWIDTH-1:0]   adr;
    logic [DWIDTH/8-1:0] sel;
    logic [DWIDTH-1:0]   dat_w;
    logic [DWIDTH-1:0]   dat_r;
    logic                ack;
    logic                stall;
    logic                err;

    modport master (
        output cyc, stb, we, adr, sel, dat_w,
        input  dat_r, ack, stall, err
    );

    modport slave (
        input  cyc, stb, we, adr, sel, dat_w,
        output dat_r, ack, stall, err
    );
endinterface

// File: rtl/wb_arbiter2.sv
// Two-master round-robin Wishbone arbiter; grant is held for a whole bus cycle.
// Optional ack watchdog enabled by defining WB_ARB_TIMEOUT_EN.
module wb_arbiter2 #(
    parameter int AWIDTH  = 32,
    parameter int DWIDTH  = 32
`ifdef WB_ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT = 255
`endif
) (
    input  logic            clk_i,
    input  logic            rst_i,
    wb_arbiter2_if.slave    m0,
    wb_arbiter2_if.slave    m1,
    wb_arbiter2_if.master   s,
    output logic [1:0]      grant
);
    // state | meaning
    // IDLE  | no owner, slave sees s_cyc=0, arbitration happens here
    // OWN0  | master 0 owns the slave until it drops cyc
    // OWN1  | master 1 owns the slave until it drops cyc
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t state;
    logic   last_owner;

`ifdef WB_ARB_TIMEOUT_EN
    logic [7:0] tmo_cnt;
    logic [1:0] err_q;
    logic       tmo_hit;

    assign tmo_hit = s.cyc && !s.ack && (tmo_cnt == 8'(TIMEOUT - 1));
`endif

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state      <= IDLE;
            last_owner <= 1'b1;
            grant      <= 2'b00;
`ifdef WB_ARB_TIMEOUT_EN
            tmo_cnt    <= '0;
            err_q      <= 2'b00;
`endif
        end else begin
`ifdef WB_ARB_TIMEOUT_EN
            err_q <= 2'b00;
`endif
            unique case (state)
                IDLE: begin
                    // On a tie the master that did not own the bus last wins.
                    if (m0.cyc && (!m1.cyc || last_owner)) begin
                        state      <= OWN0;
                        last_owner <= 1'b0;
                        grant      <= 2'b01;
                    end else if (m1.cyc) begin
                        state      <= OWN1;
                        last_owner <= 1'b1;
                        grant      <= 2'b10;
                    end
                end
                OWN0: begin
                    if (!m0.cyc) begin
                        state <= IDLE;
                        grant <= 2'b00;
                    end
`ifdef WB_ARB_TIMEOUT_EN
                    else if (tmo_hit) begin
                        state <= IDLE;
                        grant <= 2'b00;
                        err_q <= 2'b01;
                    end
`endif
                end
                OWN1: begin
                    if (!m1.cyc) begin
                        state <= IDLE;
                        grant <= 2'b00;
                    end
`ifdef WB_ARB_TIMEOUT_EN
                    else if (tmo_hit) begin
                        state <= IDLE;
                        grant <= 2'b00;
                        err_q <= 2'b10;
                    end
`endif
                end
                default: begin
                    state <= IDLE;
                    grant <= 2'b00;
                end
            endcase
`ifdef WB_ARB_TIMEOUT_EN
            if (state == IDLE || s.ack || tmo_hit) begin
                tmo_cnt <= '0;
            end else if (s.cyc) begin
                tmo_cnt <= tmo_cnt + 8'd1;
            end
`endif
        end
    end

    // Routing keys off the registered grant, so an async reset drops s_cyc immediately.
    always_comb begin
        s.cyc    = 1'b0;
        s.stb    = 1'b0;
        s.we     = 1'b0;
        s.adr    = '0;
        s.sel    = '0;
        s.dat_w  = '0;
        m0.dat_r = '0;
        m0.ack   = 1'b0;
        m0.stall = 1'b1;
        m1.dat_r = '0;
        m1.ack   = 1'b0;
        m1.stall = 1'b1;
        if (grant[0]) begin
            s.cyc    = m0.cyc;
            s.stb    = m0.stb;
            s.we     = m0.we;
            s.adr    = m0.adr;
            s.sel    = m0.sel;
            s.dat_w  = m0.dat_w;
            m0.dat_r = s.dat_r;
            m0.ack   = s.ack;
            m0.stall = s.stall;
        end else if (grant[1]) begin
            s.cyc    = m1.cyc;
            s.stb    = m1.stb;
            s.we     = m1.we;
            s.adr    = m1.adr;
            s.sel    = m1.sel;
            s.dat_w  = m1.dat_w;
            m1.dat_r = s.dat_r;
            m1.ack   = s.ack;
            m1.stall = s.stall;
        end
    end

`ifdef WB_ARB_TIMEOUT_EN
    assign m0.err = err_q[0];
    assign m1.err = err_q[1];
`else
    assign m0.err = 1'b0;
    assign m1.err = 1'b0;
`endif

endmodule
